// File: rtl/water_supply_sequencer_if.sv
// Signal bundle between the system/tank sensors and the water supply sequencer.
//   master : system side, drives enable, raw sensors and fault_clear, observes valve/status.
//   slave  : sequencer side, consumes the inputs and drives valve code and status.
// Signals:
//   enable          fill permission
//   low_level_wet   raw low sensor (1 = water at or above low mark)
//   high_level_wet  raw high sensor (1 = tank full)
//   fault_clear     single-cycle fault acknowledge
//   valvule[3:0]    valve code, 4'b1111 closed, 4'b1110 open
//   filling/fault   state flags
//   fault_code[1:0] 00 none, 01 sensor conflict, 10 fill timeout
//   state[1:0]      HOLDOFF=0, IDLE=1, FILLING=2, FAULT=3
interface water_supply_sequencer_if;
  logic       enable;
  logic       low_level_wet;
  logic       high_level_wet;
  logic       fault_clear;
  logic [3:0] valvule;
  logic       filling;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] state;

  modport master (
    output enable, low_level_wet, high_level_wet, fault_clear,
    input  valvule, filling, fault, fault_code, state
  );

  modport slave (
    input  enable, low_level_wet, high_level_wet, fault_clear,
    output valvule, filling, fault, fault_code, state
  );
endinterface

// File: rtl/water_supply_sequencer.sv
// Water supply valve sequencer.
// Synchronises and debounces the tank low/high level sensors, applies fill
// hysteresis (fill starts only with both sensors dry, stops when high is wet),
// enforces a closed hold-off after reset, fills and fault clears, aborts fills
// that exceed MAX_FILL_CYCLES and latches sensor-conflict / timeout faults.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      water_supply_sequencer_if.slave (sensor/enable inputs, valve/status outputs)
module water_supply_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned MIN_OFF_CYCLES  = 16,
  parameter int unsigned MAX_FILL_CYCLES = 1024,
  parameter int unsigned COUNTER_WIDTH   = 11
) (
  input logic                     clock,
  input logic                     reset_n,
  water_supply_sequencer_if.slave bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]          DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] OFF_LAST  = COUNTER_WIDTH'(MIN_OFF_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] FILL_LAST = COUNTER_WIDTH'(MAX_FILL_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    IDLE    = 2'd1,
    FILLING = 2'd2,
    FAULT   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Sensor path: bit 0 = low sensor, bit 1 = high sensor.
  // ---------------------------------------------------------------------------
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic                  low_lvl, high_lvl, conflict;

  always_comb begin
    sync1_d  = {bus.high_level_wet, bus.low_level_wet};
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      deb_q    <= '1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // The FSM acts on the debounced level as soon as the final qualifying
  // synchronised sample is present (deb_d), saving one cycle of latency while
  // still requiring DEBOUNCE_CYCLES consecutive samples.
  assign low_lvl  = deb_d[0];
  assign high_lvl = deb_d[1];
  assign conflict = high_lvl & ~low_lvl;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with shared saturating cycle counter.
  // ---------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]               fault_code_q, fault_code_d;
  logic [3:0]               valvule_q, valvule_d;
  logic                     filling_q, filling_d;
  logic                     fault_q, fault_d;

  always_comb begin
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + COUNTER_WIDTH'(1);
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_code_d = fault_code_q;

    if (state_q != FAULT && conflict) begin
      state_d      = FAULT;
      fault_code_d = 2'b01;
      cnt_d        = '0;
    end else begin
      case (state_q)
        HOLDOFF: begin
          if (cnt_q >= OFF_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        IDLE: begin
          if (bus.enable && !low_lvl && !high_lvl) begin
            state_d = FILLING;
            cnt_d   = '0;
          end
        end
        FILLING: begin
          // Tank full takes precedence over a timeout on the same cycle.
          if (high_lvl || !bus.enable) begin
            state_d = HOLDOFF;
            cnt_d   = '0;
          end else if (cnt_q >= FILL_LAST) begin
            state_d      = FAULT;
            fault_code_d = 2'b10;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        FAULT: begin
          if (bus.fault_clear && !conflict) begin
            state_d      = HOLDOFF;
            fault_code_d = 2'b00;
            cnt_d        = '0;
          end
        end
        default: begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered alongside the state so they decode the state register.
    valvule_d = (state_d == FILLING) ? 4'b1110 : 4'b1111;
    filling_d = (state_d == FILLING);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HOLDOFF;
      cnt_q        <= '0;
      fault_code_q <= 2'b00;
      valvule_q    <= 4'b1111;
      filling_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
      valvule_q    <= valvule_d;
      filling_q    <= filling_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.valvule    = valvule_q;
  assign bus.filling    = filling_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.state      = state_q;

endmodule

// File: doc/water_supply_sequencer.md
# water_supply_sequencer

Sequences the water-supply valve around the tank level sensors. The block synchronises and debounces the low and high level sensors, applies fill hysteresis, and enforces a minimum closed hold-off between fills. It aborts a fill that runs too long, latches faults, and drives the 4-bit valve code consumed by the supply valve driver. It sits between the raw tank sensors and the valve, and replaces direct combinational valve control.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 8, consecutive identical synchronised samples required to update a debounced level.
- MIN_OFF_CYCLES, 16, minimum cycles the valve stays closed after reset, after a fill and after a fault clear.
- MAX_FILL_CYCLES, 1024, maximum cycles in FILLING before a timeout fault.
- COUNTER_WIDTH, 11, width of the shared cycle counter; must hold MAX_FILL_CYCLES.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  fill permission from the system.
- low_level_wet  input  1  raw low sensor; 1 = water at or above the low mark.
- high_level_wet  input  1  raw high sensor; 1 = tank full.
- fault_clear  input  1  single-cycle fault acknowledge.
- valvule  output  4  valve code: 4'b1111 closed, 4'b1110 open.
- filling  output  1  1 while in FILLING.
- fault  output  1  1 while in FAULT.
- fault_code  output  2  2'b00 none, 2'b01 sensor conflict, 2'b10 fill timeout.
- state  output  2  HOLDOFF=0, IDLE=1, FILLING=2, FAULT=3.

## Operation
- Each raw sensor passes through a 2-flop synchroniser, then a debouncer. The debounced value updates only after DEBOUNCE_CYCLES consecutive samples differing from the current value. Any mismatch restarts the count.
- Debounced levels reset to 1 (tank assumed full, the safe value).
- Conflict = debounced high wet AND debounced low dry.
- Conflict has top priority in every state except FAULT: go to FAULT with fault_code 2'b01.
- HOLDOFF: valve closed; the counter counts to MIN_OFF_CYCLES-1, then the state goes to IDLE.
- IDLE: valve closed; when enable=1, debounced low=0 and debounced high=0, go to FILLING and clear the counter.
- FILLING: valve open.
  - Debounced high=1 or enable=0: go to HOLDOFF and clear the counter.
  - Otherwise, when the counter reaches MAX_FILL_CYCLES-1: go to FAULT with fault_code 2'b10.
  - If high=1 and timeout occur on the same cycle, high wins and the state goes to HOLDOFF.
- FAULT: valve closed; fault_code holds its value.
  - fault_clear=1 with no current conflict: go to HOLDOFF, clear fault_code and the counter.
  - fault_clear=1 while the conflict persists: ignored.
- Outputs are Moore-decoded from the state register only:
  - valvule = 4'b1110 iff state==FILLING, else 4'b1111.
  - filling = (state==FILLING); fault = (state==FAULT).
- The counter saturates; it never wraps.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - state=HOLDOFF, valvule=4'b1111, filling=0, fault=0, fault_code=2'b00;
  - counters=0, synchronisers=1, debounced levels=1.
- Sensor-to-valve latency for a raw edge stable from edge k:
  - synchronised at edge k+2;
  - debounced at k+1+DEBOUNCE_CYCLES;
  - state and valvule change at k+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES never changes the debounced value.
- The first fill is possible no earlier than MIN_OFF_CYCLES+1 edges after reset release.
- enable falling during FILLING closes the valve at the next edge.
- Asserting reset mid-fill closes the valve immediately, without waiting for a clock edge.
- fault_clear is sampled only in FAULT; in any other state it is ignored.

## Test plan
Use DEBOUNCE_CYCLES=4, MIN_OFF_CYCLES=8, MAX_FILL_CYCLES=32.
- Reset, then low=0, high=0, enable=1 held -> valvule=4'b1111 through HOLDOFF; FILLING with valvule=4'b1110 within 8 + sync + debounce cycles.
- While filling, raise high=1 (and low=1) -> valvule=4'b1111 exactly 6 edges after the raw edge; state=HOLDOFF for 8 cycles; no refill while low=1.
- While filling, pulse high=1 for 3 cycles -> valve stays open; a pulse of 4+ cycles closes it.
- Hold high=1, low=0 for 4+ cycles from any state -> FAULT, fault_code=2'b01, valve closed; fault_clear while the conflict holds is ignored; remove the conflict, then fault_clear -> HOLDOFF, fault_code=2'b00.
- Fill with high held 0 -> FAULT, fault_code=2'b10 exactly 32 cycles after FILLING entry; make high rise on the timeout cycle instead -> HOLDOFF, no fault.
- Assert reset_n=0 asynchronously mid-fill -> valvule=4'b1111 before the next clock edge; all outputs at reset values.
